wb_bus_arbiter: RTL and testbench

WB_BUS_ARBITER -- requirements
Module: wb_bus_arbiter

---
 rtl/wb_bus_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_wb_bus_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_bus_arbiter.sv
// Two-master Wishbone classic arbiter with stalled-strobe timeout onto one shared slave.
// Define ARB_ROUND_ROBIN_EN for round-robin contention; otherwise master 0 has fixed priority.
module wb_bus_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                      sys_clk,
    input  logic                      rst_n,

    input  logic                      m0_cyc_i,
    input  logic                      m0_stb_i,
    input  logic                      m0_we_i,
    input  logic [DATA_WIDTH/8-1:0]   m0_sel_i,
    input  logic [ADDR_WIDTH-1:0]     m0_addr_i,
    input  logic [DATA_WIDTH-1:0]     m0_data_i,
    output logic [DATA_WIDTH-1:0]     m0_data_o,
    output logic                      m0_ack_o,
    output logic                      m0_err_o,

    input  logic                      m1_cyc_i,
    input  logic                      m1_stb_i,
    input  logic                      m1_we_i,
    input  logic [DATA_WIDTH/8-1:0]   m1_sel_i,
    input  logic [ADDR_WIDTH-1:0]     m1_addr_i,
    input  logic [DATA_WIDTH-1:0]     m1_data_i,
    output logic [DATA_WIDTH-1:0]     m1_data_o,
    output logic                      m1_ack_o,
    output logic                      m1_err_o,

    output logic                      s_cyc_o,
    output logic                      s_stb_o,
    output logic                      s_we_o,
    output logic [DATA_WIDTH/8-1:0]   s_sel_o,
    output logic [ADDR_WIDTH-1:0]     s_addr_o,
    output logic [DATA_WIDTH-1:0]     s_data_o,
    input  logic [DATA_WIDTH-1:0]     s_data_i,
    input  logic                      s_ack_i,

    output logic [1:0]                grant_o
);

    localparam int unsigned CNT_WIDTH = 16;
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q;
    logic [CNT_WIDTH-1:0] stall_cnt_d;

    logic req0;
    logic req1;
    logic gnt_cyc;
    logic gnt_stb;
    logic stalled;
    logic timeout;
    logic pick1;

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;

    // Strobe/cycle of whichever master currently owns the bus.
    assign gnt_cyc = (state_q == GNT0) ? m0_cyc_i :
                     (state_q == GNT1) ? m1_cyc_i : 1'b0;
    assign gnt_stb = (state_q == GNT0) ? m0_stb_i :
                     (state_q == GNT1) ? m1_stb_i : 1'b0;

    // An ack in the same cycle suppresses the timeout.
    assign stalled = gnt_cyc & gnt_stb & ~s_ack_i;
    assign timeout = stalled & (stall_cnt_q == TIMEOUT_LAST);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_gnt_q;   // 1 when master 1 was the most recent grantee

    assign pick1 = ~last_gnt_q;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_q <= 1'b1;
        end else if (state_d != state_q) begin
            if (state_d == GNT0) begin
                last_gnt_q <= 1'b0;
            end else if (state_d == GNT1) begin
                last_gnt_q <= 1'b1;
            end
        end
    end
`else
    assign pick1 = 1'b0;
`endif

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Next-state and stall counter.
    always_comb begin
        state_d     = state_q;
        stall_cnt_d = '0;
        case (state_q)
            IDLE: begin
                if (req0 && req1) begin
                    state_d = pick1 ? GNT1 : GNT0;
                end else if (req0) begin
                    state_d = GNT0;
                end else if (req1) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                if (!m0_cyc_i) begin
                    state_d = req1 ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (!m1_cyc_i) begin
                    state_d = req0 ? GNT0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if ((state_d == state_q) && stalled && !timeout) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
    end

    // Bus mux: slave request from the owner, response back only to the owner.
    always_comb begin
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_sel_o   = '0;
        s_addr_o  = '0;
        s_data_o  = '0;
        m0_data_o = '0;
        m0_ack_o  = 1'b0;
        m0_err_o  = 1'b0;
        m1_data_o = '0;
        m1_ack_o  = 1'b0;
        m1_err_o  = 1'b0;
        grant_o   = 2'b00;
        case (state_q)
            GNT0: begin
                s_cyc_o   = m0_cyc_i;
                s_stb_o   = m0_stb_i & ~timeout;
                s_we_o    = m0_we_i;
                s_sel_o   = m0_sel_i;
                s_addr_o  = m0_addr_i;
                s_data_o  = m0_data_i;
                m0_data_o = s_data_i;
                m0_ack_o  = m0_cyc_i & s_ack_i;
                m0_err_o  = timeout;
                grant_o   = 2'b01;
            end
            GNT1: begin
                s_cyc_o   = m1_cyc_i;
                s_stb_o   = m1_stb_i & ~timeout;
                s_we_o    = m1_we_i;
                s_sel_o   = m1_sel_i;
                s_addr_o  = m1_addr_i;
                s_data_o  = m1_data_i;
                m1_data_o = s_data_i;
                m1_ack_o  = m1_cyc_i & s_ack_i;
                m1_err_o  = timeout;
                grant_o   = 2'b10;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Bench for wb_bus_arbiter: directed scenarios with literal expectations plus a randomized run,
// all checked every cycle against a transaction-level ownership model.
module tb_wb_bus_arbiter;

    localparam int TO = 4;

    logic        sys_clk = 1'b0;
    logic        rst_n;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [3:0]  m0_sel_i;
    logic [31:0] m0_addr_i, m0_data_i, m0_data_o;
    logic        m0_ack_o, m0_err_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [3:0]  m1_sel_i;
    logic [31:0] m1_addr_i, m1_data_i, m1_data_o;
    logic        m1_ack_o, m1_err_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_addr_o, s_data_o, s_data_i;
    logic        s_ack_i;
    logic [1:0]  grant_o;

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    wb_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
        .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_data_o(m0_data_o),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
        .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_data_o(m1_data_o),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_data_i(s_data_i), .s_ack_i(s_ack_i),
        .grant_o(grant_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: owner is -1 (nobody), 0 or 1; cnt counts consecutive stalled cycles.
    int owner = -1;
    int cnt   = 0;
`ifdef ARB_ROUND_ROBIN_EN
    int last  = 1;
`endif

    function automatic bit own_cyc();
        return (owner == 0) ? m0_cyc_i : (owner == 1) ? m1_cyc_i : 1'b0;
    endfunction

    function automatic bit own_stb();
        return (owner == 0) ? m0_stb_i : (owner == 1) ? m1_stb_i : 1'b0;
    endfunction

    function automatic bit own_stalled();
        return own_cyc() && own_stb() && !s_ack_i;
    endfunction

    function automatic bit own_timeout();
        return own_stalled() && (cnt == TO - 1);
    endfunction

    function automatic int contention_winner();
`ifdef ARB_ROUND_ROBIN_EN
        return (last == 1) ? 0 : 1;
`else
        return 0;
`endif
    endfunction

    // Model advances on every rising edge; reset is honoured immediately.
    initial begin
        int nxt;
        bit r0, r1, stl, tmo;
        forever begin
            @(posedge sys_clk or negedge rst_n);
            if (!rst_n) begin
                owner = -1;
                cnt   = 0;
`ifdef ARB_ROUND_ROBIN_EN
                last  = 1;
`endif
            end else begin
                r0  = m0_cyc_i && m0_stb_i;
                r1  = m1_cyc_i && m1_stb_i;
                stl = own_stalled();
                tmo = own_timeout();
                nxt = owner;
                if (owner < 0) begin
                    if (r0 && r1) nxt = contention_winner();
                    else if (r0)  nxt = 0;
                    else if (r1)  nxt = 1;
                end else if (!own_cyc()) begin
                    nxt = ((owner == 0) ? r1 : r0) ? 1 - owner : -1;
                end
                if (nxt == owner && stl && !tmo) cnt = cnt + 1;
                else cnt = 0;
`ifdef ARB_ROUND_ROBIN_EN
                if (nxt != owner && nxt >= 0) last = nxt;
`endif
                owner = nxt;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        bit tmo;
        forever begin
            @(negedge sys_clk);
            tmo = own_timeout();
            chk("grant",   32'(grant_o),  (owner == 0) ? 32'd1 : (owner == 1) ? 32'd2 : 32'd0);
            chk("s_cyc",   32'(s_cyc_o),  32'(own_cyc()));
            chk("s_stb",   32'(s_stb_o),  32'(own_stb() && !tmo));
            chk("s_we",    32'(s_we_o),   (owner == 0) ? 32'(m0_we_i) : (owner == 1) ? 32'(m1_we_i) : 32'd0);
            chk("s_sel",   32'(s_sel_o),  (owner == 0) ? 32'(m0_sel_i) : (owner == 1) ? 32'(m1_sel_i) : 32'd0);
            chk("s_addr",  s_addr_o,      (owner == 0) ? m0_addr_i : (owner == 1) ? m1_addr_i : 32'd0);
            chk("s_data",  s_data_o,      (owner == 0) ? m0_data_i : (owner == 1) ? m1_data_i : 32'd0);
            chk("m0_ack",  32'(m0_ack_o), 32'(owner == 0 && m0_cyc_i && s_ack_i));
            chk("m1_ack",  32'(m1_ack_o), 32'(owner == 1 && m1_cyc_i && s_ack_i));
            chk("m0_err",  32'(m0_err_o), 32'(owner == 0 && tmo));
            chk("m1_err",  32'(m1_err_o), 32'(owner == 1 && tmo));
            chk("m0_data", m0_data_o,     (owner == 0) ? s_data_i : 32'd0);
            chk("m1_data", m1_data_o,     (owner == 1) ? s_data_i : 32'd0);
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic drive_m0(input bit cyc, input bit stb, input bit we,
                            input logic [31:0] addr, input logic [31:0] data);
        m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we;
        m0_sel_i = 4'hF; m0_addr_i = addr; m0_data_i = data;
    endtask

    task automatic drive_m1(input bit cyc, input bit stb, input bit we,
                            input logic [31:0] addr, input logic [31:0] data);
        m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we;
        m1_sel_i = 4'hF; m1_addr_i = addr; m1_data_i = data;
    endtask

    initial begin
        rst_n    = 1'b0;
        s_ack_i  = 1'b0;
        s_data_i = '0;
        drive_m0(0, 0, 0, 0, 0);
        drive_m1(0, 0, 0, 0, 0);
        tick(); tick();
        @(negedge sys_clk);
        chk("rst grant", 32'(grant_o), 32'd0);
        chk("rst s_cyc", 32'(s_cyc_o), 32'd0);
        tick();
        rst_n = 1'b1;

        // Single-master read with ack two cycles after the request.
        tick(); drive_m0(1, 1, 0, 32'h100, 0);
        @(negedge sys_clk); chk("A grant idle", 32'(grant_o), 32'd0);
        tick();
        @(negedge sys_clk); chk("A grant", 32'(grant_o), 32'd1);
        chk("A s_addr", s_addr_o, 32'h100);
        tick(); s_ack_i = 1'b1; s_data_i = 32'hCAFEBABE;
        @(negedge sys_clk); chk("A m0_ack", 32'(m0_ack_o), 32'd1);
        chk("A m0_data", m0_data_o, 32'hCAFEBABE);
        chk("A m1_ack", 32'(m1_ack_o), 32'd0);
        tick(); s_ack_i = 1'b0; drive_m0(0, 0, 0, 0, 0);
        @(negedge sys_clk); chk("A m0_ack low", 32'(m0_ack_o), 32'd0);
        tick();
        @(negedge sys_clk); chk("A grant release", 32'(grant_o), 32'd0);

        // Direct handover from m0 to m1.
        tick(); drive_m0(1, 1, 0, 32'h300, 0);
        tick(); drive_m1(1, 1, 0, 32'h200, 0);
        @(negedge sys_clk); chk("B grant m0", 32'(grant_o), 32'd1);
        tick(); drive_m0(0, 0, 0, 0, 0);
        tick();
        @(negedge sys_clk); chk("B grant m1", 32'(grant_o), 32'd2);
        chk("B s_addr", s_addr_o, 32'h200);
        tick(); drive_m1(0, 0, 0, 0, 0);
        tick(); tick();

        // Timeout on a stalled m1 write while m0 waits.
        tick(); drive_m1(1, 1, 1, 32'h400, 32'h55);
        tick(); drive_m0(1, 1, 0, 32'h500, 0);
        @(negedge sys_clk); chk("C err stall1", 32'(m1_err_o), 32'd0);
        tick();
        tick();
        @(negedge sys_clk); chk("C err stall3", 32'(m1_err_o), 32'd0);
        tick();
        @(negedge sys_clk); chk("C err stall4", 32'(m1_err_o), 32'd1);
        chk("C stb stall4", 32'(s_stb_o), 32'd0);
        tick();
        @(negedge sys_clk); chk("C err after", 32'(m1_err_o), 32'd0);
        chk("C grant held", 32'(grant_o), 32'd2);
        chk("C stb after", 32'(s_stb_o), 32'd1);
        tick(); drive_m1(0, 0, 0, 0, 0);
        tick();
        @(negedge sys_clk); chk("C grant m0", 32'(grant_o), 32'd1);
        tick(); drive_m0(0, 0, 0, 0, 0);
        tick(); tick();

        // Ack on the would-be timeout cycle.
        tick(); drive_m0(1, 1, 0, 32'h600, 0);
        tick(); tick(); tick();
        tick(); s_ack_i = 1'b1; s_data_i = 32'h1234;
        @(negedge sys_clk); chk("D m0_ack", 32'(m0_ack_o), 32'd1);
        chk("D m0_err", 32'(m0_err_o), 32'd0);
        tick(); s_ack_i = 1'b0; drive_m0(0, 0, 0, 0, 0);
        tick(); tick();

        // Reset during an m0 stall.
        tick(); drive_m0(1, 1, 0, 32'h700, 0);
        tick();
        @(negedge sys_clk); chk("E grant", 32'(grant_o), 32'd1);
        tick(); #2; rst_n = 1'b0; #1;
        chk("E grant rst", 32'(grant_o), 32'd0);
        chk("E s_cyc rst", 32'(s_cyc_o), 32'd0);
        s_ack_i = 1'b1; #1;
        chk("E m0_ack rst", 32'(m0_ack_o), 32'd0);
        chk("E m0_err rst", 32'(m0_err_o), 32'd0);
        drive_m0(0, 0, 0, 0, 0);
        tick(); s_ack_i = 1'b0; rst_n = 1'b1;
        @(negedge sys_clk); chk("E grant idle", 32'(grant_o), 32'd0);

        // Contention right after reset, then a second contention.
        tick(); drive_m0(1, 1, 0, 32'h800, 0); drive_m1(1, 1, 0, 32'h900, 0);
        tick(); s_ack_i = 1'b1; s_data_i = 32'hA5A5;
        @(negedge sys_clk); chk("F first grant", 32'(grant_o), 32'd1);
        chk("F m0_ack", 32'(m0_ack_o), 32'd1);
        chk("F m1_ack", 32'(m1_ack_o), 32'd0);
        tick(); tick();
        tick(); s_ack_i = 1'b0; drive_m0(0, 0, 0, 0, 0); drive_m1(0, 0, 0, 0, 0);
        tick();
        @(negedge sys_clk); chk("F idle", 32'(grant_o), 32'd0);
        drive_m0(1, 1, 0, 32'h800, 0); drive_m1(1, 1, 0, 32'h900, 0);
        tick();
`ifdef ARB_ROUND_ROBIN_EN
        @(negedge sys_clk); chk("F second grant", 32'(grant_o), 32'd2);
`else
        @(negedge sys_clk); chk("F second grant", 32'(grant_o), 32'd1);
`endif
        tick(); drive_m0(0, 0, 0, 0, 0); drive_m1(0, 0, 0, 0, 0);
        tick(); tick();

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (m0_cyc_i) begin
                if ($urandom_range(0, 7) == 0) drive_m0(0, 0, 0, 0, 0);
                else m0_stb_i = ($urandom_range(0, 3) != 0);
            end else if ($urandom_range(0, 3) == 0) begin
                drive_m0(1, 1, 1'($urandom_range(0, 1)), $urandom, $urandom);
                m0_sel_i = 4'($urandom_range(0, 15));
            end
            if (m1_cyc_i) begin
                if ($urandom_range(0, 7) == 0) drive_m1(0, 0, 0, 0, 0);
                else m1_stb_i = ($urandom_range(0, 3) != 0);
            end else if ($urandom_range(0, 3) == 0) begin
                drive_m1(1, 1, 1'($urandom_range(0, 1)), $urandom, $urandom);
                m1_sel_i = 4'($urandom_range(0, 15));
            end
            s_ack_i  = ($urandom_range(0, 2) == 0);
            s_data_i = $urandom;
            if (i % 700 == 352) rst_n = 1'b1;
            if (i % 700 == 350) begin
                #2;
                rst_n = 1'b0;
            end
        end
        tick();
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
